// File: rtl/digit_scan_counter.sv
// Multi-digit BCD up/down event counter with a scanned digit output for a
// multiplexed display; count and manual-step pulses arrive asynchronously.
module digit_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4000,
  parameter int SEL_W    = $clog2(DIGITS)
) (
  input  logic                  f4m,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  cnt_in,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  scan_mode,
  input  logic                  step,
  output logic [4*DIGITS-1:0]   value,
  output logic [SEL_W-1:0]      sel,
  output logic [3:0]            digit,
  output logic                  carry
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int VW    = 4 * DIGITS;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);

  logic cnt_s1, cnt_s2, cnt_d;
  logic step_s1, step_s2, step_d;
  logic cnt_fall, step_fall;

  logic [VW-1:0]    inc_val, dec_val, load_val;
  logic             inc_wrap, dec_wrap;
  logic [PRE_W-1:0] presc;
  logic             mode_q;
  logic [SEL_W-1:0] sel_next;

  // Two-flop synchronisers plus a delay flop for falling-edge detection.
  always_ff @(posedge f4m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_s1  <= 1'b0;
      cnt_s2  <= 1'b0;
      cnt_d   <= 1'b0;
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_d  <= 1'b0;
    end else begin
      cnt_s1  <= cnt_in;
      cnt_s2  <= cnt_s1;
      cnt_d   <= cnt_s2;
      step_s1 <= step;
      step_s2 <= step_s1;
      step_d  <= step_s2;
    end
  end

  assign cnt_fall  = ~cnt_s2 & cnt_d;
  assign step_fall = ~step_s2 & step_d;

  // Ripple the BCD carry/borrow digit by digit; leftover carry means wrap.
  always_comb begin
    inc_val  = value;
    dec_val  = value;
    load_val = preset;
    inc_wrap = 1'b1;
    dec_wrap = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_wrap) begin
        if (value[4*i +: 4] >= 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = value[4*i +: 4] + 4'd1;
          inc_wrap = 1'b0;
        end
      end
      if (dec_wrap) begin
        if (value[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = value[4*i +: 4] - 4'd1;
          dec_wrap = 1'b0;
        end
      end
      if (preset[4*i +: 4] > 4'd9) begin
        load_val[4*i +: 4] = 4'd9;
      end
    end
  end

  // Count register: a count edge losing to clr/load is simply dropped.
  always_ff @(posedge f4m or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      carry <= 1'b0;
    end else if (clr) begin
      value <= '0;
      carry <= 1'b0;
    end else if (load) begin
      value <= load_val;
      carry <= 1'b0;
    end else if (cnt_fall) begin
      value <= dir ? inc_val : dec_val;
      carry <= dir ? inc_wrap : dec_wrap;
    end else begin
      carry <= 1'b0;
    end
  end

  assign sel_next = (sel == SEL_LAST) ? '0 : sel + 1'b1;

  // A scan_mode change restarts the prescaler and suppresses any advance on that edge.
  always_ff @(posedge f4m or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      sel    <= '0;
      mode_q <= 1'b0;
    end else begin
      mode_q <= scan_mode;
      if (scan_mode != mode_q) begin
        presc <= '0;
      end else if (scan_mode) begin
        if (presc == PRE_LAST) begin
          presc <= '0;
          sel   <= sel_next;
        end else begin
          presc <= presc + 1'b1;
        end
      end else begin
        presc <= '0;
        if (step_fall) begin
          sel <= sel_next;
        end
      end
    end
  end

  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel == SEL_W'(i)) begin
        digit = value[4*(DIGITS-1-i) +: 4];
      end
    end
  end

endmodule

// File: doc/digit_scan_counter.md
DIGIT_SCAN_COUNTER -- requirements
Module: digit_scan_counter

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits, legal range 2..8.
REQ-002 Parameter SCAN_DIV, default 4000: f4m cycles per auto-scan step, legal range >= 2.
REQ-003 Parameter SEL_W, derived as clog2(DIGITS): width of the digit-select output.
REQ-004 f4m  in  1  sole clock, rising-edge active.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 clr  in  1  synchronous clear of the count, level-sensitive.
REQ-007 cnt_in  in  1  asynchronous count pulse; one count per falling edge.
REQ-008 dir  in  1  count direction: 1 = up, 0 = down.
REQ-009 load  in  1  synchronous preset load, level-sensitive.
REQ-010 preset  in  4*DIGITS  BCD preset value; digit 0 is in bits [3:0].
REQ-011 scan_mode  in  1  1 = auto scan, 0 = manual scan.
REQ-012 step  in  1  asynchronous manual scan pulse; one advance per falling edge.
REQ-013 value  out  4*DIGITS  current BCD count, registered.
REQ-014 sel  out  SEL_W  currently displayed digit position, registered.
REQ-015 digit  out  4  BCD digit at position sel; combinational from value and sel.
REQ-016 carry  out  1  one-cycle pulse on wrap-around in either direction.

Function
REQ-017 cnt_in and step SHALL each pass through a 2-flop synchroniser followed by a delay register.
REQ-018 A falling edge SHALL be detected when the synchronised signal is 0 and its delayed copy is 1.
REQ-019 Count event timing: value updates on the 2nd rising f4m edge after the edge that first samples cnt_in low.
REQ-020 Count priority SHALL be clr > load > count event; a count event that loses priority is discarded, not queued.
REQ-021 clr=1 SHALL set value to 0 on the next edge, with carry=0.
REQ-022 load=1 SHALL copy preset into value; any preset digit >9 SHALL load as 9.
REQ-023 Up-count SHALL be per-digit BCD: a digit at 9 becomes 0 and increments the next digit; otherwise the digit increments.
REQ-024 Up from all-9s SHALL wrap to 0 and assert carry for exactly one cycle.
REQ-025 Down-count SHALL be per-digit BCD: a digit at 0 becomes 9 and borrows from the next digit; otherwise the digit decrements.
REQ-026 Down from 0 SHALL wrap to all-9s and assert carry for exactly one cycle.
REQ-027 carry SHALL be 0 in every cycle without a wrap.
REQ-028 dir is sampled in the cycle of the count event; dir changes at any other time have no effect.
REQ-029 sel=0 SHALL select the most-significant digit, value[4*DIGITS-1 -: 4]; sel=k selects digit DIGITS-1-k.
REQ-030 sel SHALL advance by 1 and wrap from DIGITS-1 to 0; it never holds a value >= DIGITS.
REQ-031 Auto mode: a prescaler counts 0..SCAN_DIV-1; sel advances on the cycle the prescaler is at SCAN_DIV-1, then the prescaler returns to 0.
REQ-032 Auto mode: step edges SHALL be ignored.
REQ-033 Manual mode: the prescaler holds 0; each detected step falling edge advances sel once.
REQ-034 Any change of scan_mode SHALL clear the prescaler on the same edge; sel is unchanged.
REQ-035 clr and load SHALL NOT affect sel or the prescaler.

Reset
REQ-036 rst_n=0 SHALL immediately clear value, sel, carry, the prescaler, and all synchroniser and delay flops, independent of f4m.
REQ-037 The first count or step edge SHALL be recognised only after a full high-then-low sequence has been synchronised following reset release.
REQ-038 Reset asserted mid-count or mid-scan SHALL abandon the operation; nothing is replayed after release.

Verification
REQ-039 DIGITS=4, up, preset 0x0999, one cnt_in pulse -> value=0x1000, carry=0.
REQ-040 DIGITS=4, up from 0x9999, one pulse -> value=0x0000, carry high for exactly 1 cycle; then down, one pulse -> value=0x9999, carry pulses once.
REQ-041 preset=0x12A4 with load=1 -> value=0x1294; load and clr both 1 while a count edge arrives -> value=0x0000.
REQ-042 Auto mode, SCAN_DIV=4, DIGITS=3 -> sel sequence 0,1,2,0 with each value held 4 cycles; with value=0x123, digit = 1,2,3 respectively.
REQ-043 Manual mode, 5 step pulses with DIGITS=4 -> sel=1; cnt_in held high for 100 cycles then low -> exactly one count.
REQ-044 rst_n pulsed low asynchronously mid-scan with value=0x5678 -> value, sel and carry are 0 before the next f4m edge.
